// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable serial pattern detector with a small
// control FSM (IDLE -> ARMED -> DONE). Software loads pattern, length, overlap
// mode and match target while IDLE, then arms the detector with start.
// Optional feature macro: SEQ_DET_TIMEOUT_EN adds an ARMED-state inactivity
// timeout of TIMEOUT cycles. When it is undefined, timeout is tied low.
//
// Serial input handshake: din is sampled only on cycles where din_valid is 1.
// There is no back-pressure (no ready). The detector consumes one bit per
// valid cycle while ARMED and ignores din in every other state.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               din_valid,
  input  logic               din,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               cfg_err,
  output logic               timeout,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W+1)'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               cfg_valid_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               match_q;
  logic               cfg_err_q;
  logic               timeout_q;

  logic               in_idle, in_armed;
  logic               len_ok;
  logic               beat;
  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               full;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic               final_hit;
  logic               tmo_hit;

  assign in_idle  = (state_q == IDLE);
  assign in_armed = (state_q == ARMED);
  assign len_ok   = (cfg_len != '0) && ({1'b0, cfg_len} <= MAX_LEN_X);
  // abort wins over a same-cycle data bit: the bit is dropped entirely.
  assign beat     = in_armed && din_valid && !abort;
  assign hist_new = {hist_q[MAX_LEN-2:0], din};
  assign fill_inc = {1'b0, fill_q} + 1'b1;
  assign full     = (fill_inc >= {1'b0, len_q});
  assign hit      = beat && full && ((hist_new & len_mask) == (pat_q & len_mask));
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign final_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

  // Mask selecting the low len_q bits of history and pattern.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

`ifdef SEQ_DET_TIMEOUT_EN
  logic [31:0] tmr_q;

  // Inactivity timer: abort and a hit both take priority over expiry.
  assign tmo_hit = in_armed && !abort && !hit && (tmr_q == 32'(TIMEOUT - 1));

  // Timer counts ARMED cycles since start or since the last hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (in_idle && start && cfg_valid_q) begin
      tmr_q <= '0;
    end else if (in_armed) begin
      tmr_q <= hit ? '0 : tmr_q + 32'd1;
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT != 0);
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_valid_q) state_d = ARMED;
      end
      ARMED: begin
        if (abort)          state_d = IDLE;
        else if (final_hit) state_d = DONE;
        else if (tmo_hit)   state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Configuration, detection history, match counter and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      cfg_valid_q <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      match_q   <= hit;
      timeout_q <= tmo_hit;
      cfg_err_q <= 1'b0;
      if (in_idle && cfg_we) begin
        if (len_ok) begin
          pat_q       <= cfg_pattern;
          len_q       <= cfg_len;
          ovl_q       <= cfg_overlap;
          tgt_q       <= cfg_target;
          cfg_valid_q <= 1'b1;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (in_idle && start) begin
        if (cfg_valid_q) begin
          hist_q <= '0;
          fill_q <= '0;
          cnt_q  <= '0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (beat) begin
        hist_q <= hist_new;
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
        if (hit && !ovl_q) fill_q <= '0;
        else if (full)     fill_q <= len_q;
        else               fill_q <= fill_inc[LEN_W-1:0];
      end
      if (hit) cnt_q <= cnt_inc;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed vectors; expected output events go into a
// queue and a monitor pops and compares them whenever the DUT pulses an event.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int W       = CNT_W + 4;

  logic               clk, rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start, abort, din_valid, din;
  logic               busy, match, done, cfg_err, timeout;
  logic [CNT_W-1:0]   match_cnt;
  logic [1:0]         state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act, mon_exp;
  int checks   = 0;
  int failures = 0;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .din_valid(din_valid), .din(din), .busy(busy), .match(match), .match_cnt(match_cnt),
    .done(done), .cfg_err(cfg_err), .timeout(timeout), .state_dbg(state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event word: {match, done, cfg_err, timeout, match_cnt}.
  function automatic logic [W-1:0] ev(input logic m, input logic d, input logic e,
                                      input logic t, input logic [CNT_W-1:0] c);
    return {m, d, e, t, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT event pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (match || done || cfg_err || timeout)) begin
      mon_act = {match, done, cfg_err, timeout, match_cnt};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected: got=%h expected=none at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL event: got=%h expected=%h at %0t", mon_act, mon_exp, $time);
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                     input logic o, input logic [CNT_W-1:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    din_valid = 1'b1; din = b;
    step();
    din_valid = 1'b0;
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  // Wait a bounded time for all expected events to be observed.
  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got=%0d pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_match", 32'(match), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst = 1'b0;
    step();

    // 1) overlapping 1011, unlimited target; gap cycle and ignored start mid-run.
    cfg(8'b1011, 4, 1'b1, 0);
    arm();
    check("t1_busy_armed", 32'(busy), 1);
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    exp_q.push_back(ev(1, 0, 0, 0, 2));
    bits(16'b1011, 4);
    step();
    arm();
    bits(16'b011, 3);
    drain("t1");
    check("t1_busy", 32'(busy), 1);
    check("t1_cnt", 32'(match_cnt), 2);
    stop();
    check("t1_busy_after_abort", 32'(busy), 0);
    check("t1_cnt_held", 32'(match_cnt), 2);

    // 2a) non-overlapping 1010 on 101010: one match.
    cfg(8'b1010, 4, 1'b0, 0);
    arm();
    check("t2a_cnt_cleared", 32'(match_cnt), 0);
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    bits(16'b101010, 6);
    drain("t2a");
    check("t2a_cnt", 32'(match_cnt), 1);
    stop();

    // 2b) overlapping: matches at beats 4 and 6.
    cfg(8'b1010, 4, 1'b1, 0);
    arm();
    check("t2b_cnt_cleared", 32'(match_cnt), 0);
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    exp_q.push_back(ev(1, 0, 0, 0, 2));
    bits(16'b101010, 6);
    drain("t2b");
    check("t2b_cnt", 32'(match_cnt), 2);
    stop();

    // 3) 111, target 3, nine ones: done with third match, busy drops a cycle later.
    cfg(8'b111, 3, 1'b0, 3);
    arm();
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    exp_q.push_back(ev(1, 0, 0, 0, 2));
    exp_q.push_back(ev(1, 1, 0, 0, 3));
    bits(16'h1FF, 9);
    check("t3_busy_done", 32'(busy), 1);
    check("t3_done", 32'(done), 1);
    step();
    check("t3_busy_idle", 32'(busy), 0);
    check("t3_done_low", 32'(done), 0);
    check("t3_cnt", 32'(match_cnt), 3);
    drain("t3");

    // 3b) full-length pattern, target 1.
    cfg(8'b10100101, 8, 1'b0, 1);
    arm();
    exp_q.push_back(ev(1, 1, 0, 0, 1));
    bits(16'b10100101, 8);
    step();
    drain("t3b");
    check("t3b_busy", 32'(busy), 0);

    // 3c) single-bit pattern, target 2.
    cfg(8'b1, 1, 1'b0, 2);
    arm();
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    exp_q.push_back(ev(1, 1, 0, 0, 2));
    bits(16'b011, 3);
    step();
    drain("t3c");
    check("t3c_busy", 32'(busy), 0);

    // 5a) config write while ARMED ignored; abort beats completing bit.
    cfg(8'b1011, 4, 1'b0, 0);
    arm();
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    exp_q.push_back(ev(1, 0, 0, 0, 2));
    bits(16'b1011, 4);
    cfg(8'b0101, 4, 1'b1, 0);
    bits(16'b1011, 4);
    drain("t5a_pre");
    bits(16'b101, 3);
    abort = 1'b1; din_valid = 1'b1; din = 1'b1;
    step();
    abort = 1'b0; din_valid = 1'b0;
    check("t5a_busy", 32'(busy), 0);
    check("t5a_cnt", 32'(match_cnt), 2);
    step();
    step();

    // 5b) reset mid-run clears config: next start flags cfg_err.
    arm();
    check("t5b_cnt_cleared", 32'(match_cnt), 0);
    bits(16'b10, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5b_busy", 32'(busy), 0);
    check("t5b_match", 32'(match), 0);
    check("t5b_cnt", 32'(match_cnt), 0);
    check("t5b_done", 32'(done), 0);
    exp_q.push_back(ev(0, 0, 1, 0, 0));
    arm();
    check("t5b_busy_after_start", 32'(busy), 0);
    drain("t5b");

    // 4) illegal lengths and start without valid config.
    exp_q.push_back(ev(0, 0, 1, 0, 0));
    cfg(8'b11, 0, 1'b0, 0);
    exp_q.push_back(ev(0, 0, 1, 0, 0));
    arm();
    check("t4_busy", 32'(busy), 0);
    exp_q.push_back(ev(0, 0, 1, 0, 0));
    cfg(8'b11, 4'(MAX_LEN + 1), 1'b0, 0);
    drain("t4");
    cfg(8'b11, 2, 1'b0, 0);
    arm();
    check("t4_busy_legal", 32'(busy), 1);

`ifdef SEQ_DET_TIMEOUT_EN
    // 6) zeros against 11 time out after 10 ARMED cycles.
    stop();
    arm();
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    bits(16'h0, 10);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    drain("t6");
`else
    stop();
`endif

    step();
    drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
